// File: rtl/fp_ret_collect.sv
// Collects the three FP retire channels into an in-order FIFO and hands them to retire logic.
// Optional zero-latency bypass on an empty FIFO when FP_RET_BYPASS_EN is defined.
module fp_ret_collect #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] u1_ret,
  input  logic        u1_ret_en,
  input  logic [13:0] u3_ret,
  input  logic        u3_ret_en,
  input  logic [13:0] u5_ret,
  input  logic        u5_ret_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_port,
  output logic [13:0] out_ret,
  output logic        ret_stall,
  output logic [4:0]  flags,
  input  logic        flags_clr,
  output logic        ovf_err
);

  localparam int unsigned CW = PTR_W + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [13:0]      ret_mem  [DEPTH];
  logic [1:0]       port_mem [DEPTH];
  logic [CW-1:0]    wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic [1:0]       last_port_q;
  logic [13:0]      last_ret_q;

  logic [2:0]       en;
  logic [13:0]      word [3];
  logic             fifo_valid, pop_fifo, pop_any, drop;
  logic [2:0]       skip, wr_en;
  logic [PTR_W-1:0] wr_slot [3];
  logic [PTR_W-1:0] rd_idx;
  logic [CW-1:0]    free, n_push;

  assign en         = {u5_ret_en, u3_ret_en, u1_ret_en};
  assign word[0]    = u1_ret;
  assign word[1]    = u3_ret;
  assign word[2]    = u5_ret;
  assign fifo_valid = (count_q != '0);
  assign rd_idx     = rd_ptr_q[PTR_W-1:0];
  assign pop_fifo   = fifo_valid && out_ready;
  assign pop_any    = out_valid && out_ready;

`ifdef FP_RET_BYPASS_EN
  logic        byp_valid;
  logic [1:0]  byp_port;
  logic [13:0] byp_ret;

  assign byp_valid = !fifo_valid && (en != 3'b000);

  always_comb begin
    byp_port = 2'd2;
    byp_ret  = u5_ret;
    if (u1_ret_en) begin
      byp_port = 2'd0;
      byp_ret  = u1_ret;
    end else if (u3_ret_en) begin
      byp_port = 2'd1;
      byp_ret  = u3_ret;
    end
  end

  // A consumed bypass channel is the lowest set enable; it never enters the FIFO.
  assign skip = (byp_valid && out_ready) ? (en & (~en + 3'd1)) : 3'b000;

  always_comb begin
    out_valid = fifo_valid || byp_valid;
    if (fifo_valid) begin
      out_port = port_mem[rd_idx];
      out_ret  = ret_mem[rd_idx];
    end else if (byp_valid) begin
      out_port = byp_port;
      out_ret  = byp_ret;
    end else begin
      out_port = last_port_q;
      out_ret  = last_ret_q;
    end
  end
`else
  assign skip = 3'b000;

  always_comb begin
    out_valid = fifo_valid;
    if (fifo_valid) begin
      out_port = port_mem[rd_idx];
      out_ret  = ret_mem[rd_idx];
    end else begin
      out_port = last_port_q;
      out_ret  = last_ret_q;
    end
  end
`endif

  // The slot freed by a same-cycle pop is available to this cycle's pushes.
  assign free = DepthC - count_q + CW'(pop_fifo);

  always_comb begin
    n_push = '0;
    drop   = 1'b0;
    wr_en  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      wr_slot[i] = wr_ptr_q[PTR_W-1:0] + n_push[PTR_W-1:0];
      if (en[i] && !skip[i]) begin
        if (n_push < free) begin
          wr_en[i] = 1'b1;
          n_push   = n_push + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  assign count_d = count_q + n_push - CW'(pop_fifo);

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wr_en[k]) begin
        ret_mem[wr_slot[k]]  <= word[k];
        port_mem[wr_slot[k]] <= 2'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_port_q <= 2'd0;
      last_ret_q  <= 14'd0;
      ret_stall   <= 1'b0;
      flags       <= 5'd0;
      ovf_err     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_q + n_push;
      rd_ptr_q  <= rd_ptr_q + CW'(pop_fifo);
      count_q   <= count_d;
      // Keep headroom for three completions already in flight when issue stops.
      ret_stall <= (DepthC - count_d) < CW'(3);
      ovf_err   <= ovf_err | drop;
      flags     <= (flags_clr ? 5'd0 : flags) | (pop_any ? out_ret[4:0] : 5'd0);
      if (pop_any) begin
        last_port_q <= out_port;
        last_ret_q  <= out_ret;
      end
    end
  end

endmodule

// File: tb/tb_fp_ret_collect.sv
// Self-checking bench for fp_ret_collect: queue-based model compared every cycle plus literal checks.
module tb_fp_ret_collect;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] u1_ret, u3_ret, u5_ret;
  logic        u1_ret_en, u3_ret_en, u5_ret_en;
  logic        out_valid, out_ready;
  logic [1:0]  out_port;
  logic [13:0] out_ret;
  logic        ret_stall;
  logic [4:0]  flags;
  logic        flags_clr;
  logic        ovf_err;

  fp_ret_collect #(.DEPTH(8), .PTR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .u1_ret    (u1_ret),
    .u1_ret_en (u1_ret_en),
    .u3_ret    (u3_ret),
    .u3_ret_en (u3_ret_en),
    .u5_ret    (u5_ret),
    .u5_ret_en (u5_ret_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_port  (out_port),
    .out_ret   (out_ret),
    .ret_stall (ret_stall),
    .flags     (flags),
    .flags_clr (flags_clr),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  port;
    logic [13:0] ret;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  ent_t       mq[$];
  ent_t       m_last  = '0;
  logic [4:0] m_flags = '0;
  logic       m_ovf   = 1'b0;
  logic       m_stall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: in-order queue; outputs derived from its head, state advanced once per cycle.
  always @(negedge clk) begin
    ent_t inc[$];
    ent_t head;
    bit   ev;
    bit   byp;
    if (chk_en) begin
      inc.delete();
      if (u1_ret_en) inc.push_back(ent_t'({2'd0, u1_ret}));
      if (u3_ret_en) inc.push_back(ent_t'({2'd1, u3_ret}));
      if (u5_ret_en) inc.push_back(ent_t'({2'd2, u5_ret}));
      byp = 1'b0;
      if (mq.size() > 0) begin
        ev   = 1'b1;
        head = mq[0];
`ifdef FP_RET_BYPASS_EN
      end else if (inc.size() > 0) begin
        ev   = 1'b1;
        head = inc[0];
        byp  = 1'b1;
`endif
      end else begin
        ev   = 1'b0;
        head = m_last;
      end
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out_port", 32'(out_port), 32'(head.port));
      chk("out_ret", 32'(out_ret), 32'(head.ret));
      chk("flags", 32'(flags), 32'(m_flags));
      chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
      chk("ret_stall", 32'(ret_stall), 32'(m_stall));
      if (rst) begin
        mq.delete();
        m_last  = '0;
        m_flags = '0;
        m_ovf   = 1'b0;
        m_stall = 1'b0;
      end else begin
        if (flags_clr) m_flags = '0;
        if (ev && out_ready) begin
          m_flags = m_flags | head.ret[4:0];
          m_last  = head;
          if (byp) void'(inc.pop_front());
          else     void'(mq.pop_front());
        end
        foreach (inc[i]) begin
          if (mq.size() < DEPTH) mq.push_back(inc[i]);
          else                   m_ovf = 1'b1;
        end
        m_stall = (DEPTH - mq.size()) < 3;
      end
    end
  end

  task automatic drive(input logic e1, input logic [13:0] w1, input logic e3,
                       input logic [13:0] w3, input logic e5, input logic [13:0] w5,
                       input logic rdy, input logic clr);
    u1_ret_en = e1; u1_ret = w1;
    u3_ret_en = e3; u3_ret = w3;
    u5_ret_en = e5; u5_ret = w5;
    out_ready = rdy;
    flags_clr = clr;
    @(posedge clk);
    #1;
    u1_ret_en = 1'b0;
    u3_ret_en = 1'b0;
    u5_ret_en = 1'b0;
    flags_clr = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  initial begin
    rst = 1'b1;
    u1_ret = '0; u3_ret = '0; u5_ret = '0;
    u1_ret_en = 1'b0; u3_ret_en = 1'b0; u5_ret_en = 1'b0;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    chk("reset ret_stall", 32'(ret_stall), 32'd0);
    chk("reset ovf_err", 32'(ovf_err), 32'd0);

    // Single u1 completion.
    drive(1, 14'h0001, 0, 0, 0, 0, 1, 0);
`ifndef FP_RET_BYPASS_EN
    chk("t1 valid", 32'(out_valid), 32'd1);
    chk("t1 port", 32'(out_port), 32'd0);
    chk("t1 ret", 32'(out_ret), 32'h0001);
`endif
    idle(1, 1);
    chk("t1 flags", 32'(flags), 32'b00001);
    chk("t1 model empty", 32'(mq.size()), 32'd0);

    // Three completions in one cycle retire in u1,u3,u5 order.
    drive(1, 14'h0100, 1, 14'h0204, 1, 14'h0310, 1, 0);
    idle(3, 1);
    chk("t2 flags", 32'(flags), 32'b10101);
    chk("t2 last ret", 32'(out_ret), 32'h0310);
    chk("t2 last port", 32'(out_port), 32'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t2 clr", 32'(flags), 32'd0);

    // Fill with out_ready low, then overflow.
    drive(1, 14'h1000, 1, 14'h1020, 1, 14'h1040, 0, 0);
    chk("t3 stall c3", 32'(ret_stall), 32'd0);
    drive(1, 14'h1060, 1, 14'h1080, 1, 14'h10A0, 0, 0);
    chk("t3 stall c6", 32'(ret_stall), 32'd1);
    chk("t3 ovf c6", 32'(ovf_err), 32'd0);
    chk("t3 model c6", 32'(mq.size()), 32'd6);
    drive(1, 14'h10C0, 1, 14'h10E0, 1, 14'h1100, 0, 0);
    chk("t4 ovf", 32'(ovf_err), 32'd1);
    chk("t4 model full", 32'(mq.size()), 32'd8);
    chk("t4 head", 32'(out_ret), 32'h1000);
    idle(9, 1);
    chk("t4 drain last ret", 32'(out_ret), 32'h10E0);
    chk("t4 drain last port", 32'(out_port), 32'd1);
    chk("t4 drain valid", 32'(out_valid), 32'd0);
    chk("t4 drain stall", 32'(ret_stall), 32'd0);

    // Clear-and-OR on the same pop, then clear alone.
    drive(1, 14'h0003, 0, 0, 0, 0, 1, 0);
    idle(1, 1);
    chk("t5 flags 00011", 32'(flags), 32'b00011);
    drive(1, 14'h0008, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("t5 clr+pop", 32'(flags), 32'b01000);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t5 clr only", 32'(flags), 32'd0);

    // Reset with five entries queued.
    drive(1, 14'h2000, 1, 14'h2020, 1, 14'h2040, 0, 0);
    drive(1, 14'h2060, 0, 0, 1, 14'h20A0, 0, 0);
    chk("t6 queued valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6 rst valid", 32'(out_valid), 32'd0);
    chk("t6 rst stall", 32'(ret_stall), 32'd0);
    chk("t6 rst ovf", 32'(ovf_err), 32'd0);
    chk("t6 rst ret", 32'(out_ret), 32'd0);
    chk("t6 model empty", 32'(mq.size()), 32'd0);

`ifdef FP_RET_BYPASS_EN
    u3_ret_en = 1'b1;
    u3_ret    = 14'h0302;
    out_ready = 1'b1;
    #1;
    chk("byp valid", 32'(out_valid), 32'd1);
    chk("byp port", 32'(out_port), 32'd1);
    chk("byp ret", 32'(out_ret), 32'h0302);
    @(posedge clk);
    #1;
    u3_ret_en = 1'b0;
    chk("byp no store", 32'(out_valid), 32'd0);
    chk("byp flags", 32'(flags), 32'b00010);
`endif

    idle(2, 1);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
